aes_engine_stream_ctrl: RTL and testbench

Engine-side responder to the AES HWPE control FSM. It accepts the engine start/clear/enable controls, consumes 32-bit plaintext words from the streamer source, and assembles them into 128-bit blocks for the cipher core. It serialises each ciphertext block back into 32-bit words on the streamer sink and reports busy/done flags to the controller. It sits between the HWPE streamer and the AES round core inside the engine.

---
 rtl/aes_engine_stream_ctrl.sv | 132 +++++++++++++
 tb/tb_aes_engine_stream_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_engine_stream_ctrl.sv
// Engine-side stream controller for the AES HWPE: packs 32-bit plaintext words into
// 128-bit core blocks and serialises ciphertext blocks back out. Optional: AES_ENGINE_BYTESWAP_EN.
module aes_engine_stream_ctrl #(
    parameter int unsigned NB_BLOCKS_W  = 16,
    parameter int unsigned CORE_MIN_LAT = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   ctrl_clear_i,
    input  logic                   ctrl_start_i,
    input  logic                   ctrl_enable_i,
    input  logic [NB_BLOCKS_W-1:0] nb_blocks_i,
    input  logic [31:0]            plaintext_data_i,
    input  logic                   plaintext_valid_i,
    output logic                   plaintext_ready_o,
    output logic [31:0]            ciphertext_data_o,
    output logic                   ciphertext_valid_o,
    input  logic                   ciphertext_ready_i,
    output logic                   core_start_o,
    output logic [127:0]           core_block_o,
    input  logic                   core_done_i,
    input  logic [127:0]           core_block_i,
    output logic                   flags_busy_o,
    output logic                   flags_done_o,
    output logic [NB_BLOCKS_W-1:0] flags_blk_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CIPHER,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 r_state, w_state_next;
    logic [NB_BLOCKS_W-1:0] r_nb, r_blk_cnt, w_blk_inc;
    logic [1:0]             r_word_cnt;
    logic [127:0]           r_in_buf, r_out_buf;
    logic                   r_start_pend;
    logic                   w_in_hs, w_out_hs, w_core_start, w_core_done, w_last_word;
    logic [31:0]            w_in_word;

    generate
        if (CORE_MIN_LAT < 1) begin : g_lat_chk
            $error("aes_engine_stream_ctrl requires CORE_MIN_LAT >= 1");
        end
    endgenerate

    function automatic logic [31:0] f_swap(input logic [31:0] w);
`ifdef AES_ENGINE_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    always_comb begin
        plaintext_ready_o  = (r_state == S_LOAD) && ctrl_enable_i && !ctrl_clear_i;
        ciphertext_valid_o = (r_state == S_DRAIN);
        ciphertext_data_o  = (r_state == S_DRAIN) ? f_swap(r_out_buf[127:96]) : '0;
        core_start_o       = (r_state == S_CIPHER) && r_start_pend && ctrl_enable_i && !ctrl_clear_i;
        core_block_o       = r_in_buf;
        flags_busy_o       = (r_state != S_IDLE);
        flags_done_o       = (r_state == S_DONE);
        flags_blk_cnt_o    = r_blk_cnt;
    end

    // Done is only honoured once the start pulse has actually been issued.
    always_comb begin
        w_in_hs      = plaintext_ready_o && plaintext_valid_i;
        w_out_hs     = ciphertext_valid_o && ciphertext_ready_i;
        w_core_start = core_start_o;
        w_core_done  = core_done_i && (r_state == S_CIPHER) && !r_start_pend;
        w_last_word  = (r_word_cnt == 2'd3);
        w_blk_inc    = r_blk_cnt + NB_BLOCKS_W'(1);
        w_in_word    = f_swap(plaintext_data_i);
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (ctrl_start_i) w_state_next = (nb_blocks_i == '0) ? S_DONE : S_LOAD;
            S_LOAD:   if (w_in_hs && w_last_word) w_state_next = S_CIPHER;
            S_CIPHER: if (w_core_done) w_state_next = S_DRAIN;
            S_DRAIN:  if (w_out_hs && w_last_word) w_state_next = (w_blk_inc == r_nb) ? S_DONE : S_LOAD;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_nb         <= '0;
            r_blk_cnt    <= '0;
            r_word_cnt   <= '0;
            r_in_buf     <= '0;
            r_out_buf    <= '0;
            r_start_pend <= 1'b0;
        end else if (ctrl_clear_i) begin
            r_state      <= S_IDLE;
            r_nb         <= '0;
            r_blk_cnt    <= '0;
            r_word_cnt   <= '0;
            r_in_buf     <= '0;
            r_out_buf    <= '0;
            r_start_pend <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE && ctrl_start_i) begin
                r_nb       <= nb_blocks_i;
                r_blk_cnt  <= '0;
                r_word_cnt <= '0;
            end
            // Both buffers shift by one word per handshake so word 0 sits in the top lane.
            if (w_in_hs) begin
                r_in_buf   <= {r_in_buf[95:0], w_in_word};
                r_word_cnt <= r_word_cnt + 2'd1;
                if (w_last_word) r_start_pend <= 1'b1;
            end
            if (w_core_start) r_start_pend <= 1'b0;
            if (w_core_done) r_out_buf <= core_block_i;
            if (w_out_hs) begin
                r_out_buf  <= {r_out_buf[95:0], 32'h0};
                r_word_cnt <= r_word_cnt + 2'd1;
                if (w_last_word) r_blk_cnt <= w_blk_inc;
            end
        end
    end

endmodule

// File: tb/tb_aes_engine_stream_ctrl.sv
// Randomised self-checking bench for aes_engine_stream_ctrl with a transaction-level model.
module tb_aes_engine_stream_ctrl;

    localparam int unsigned NBW = 16;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           ctrl_clear_i = 1'b0, ctrl_start_i = 1'b0, ctrl_enable_i = 1'b0;
    logic [NBW-1:0] nb_blocks_i = '0;
    logic [31:0]    plaintext_data_i = '0;
    logic           plaintext_valid_i = 1'b0, plaintext_ready_o;
    logic [31:0]    ciphertext_data_o;
    logic           ciphertext_valid_o, ciphertext_ready_i = 1'b0;
    logic           core_start_o, core_done_i = 1'b0;
    logic [127:0]   core_block_o, core_block_i = '0;
    logic           flags_busy_o, flags_done_o;
    logic [NBW-1:0] flags_blk_cnt_o;

    aes_engine_stream_ctrl #(.NB_BLOCKS_W(NBW), .CORE_MIN_LAT(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .ctrl_clear_i(ctrl_clear_i), .ctrl_start_i(ctrl_start_i), .ctrl_enable_i(ctrl_enable_i),
        .nb_blocks_i(nb_blocks_i),
        .plaintext_data_i(plaintext_data_i), .plaintext_valid_i(plaintext_valid_i),
        .plaintext_ready_o(plaintext_ready_o),
        .ciphertext_data_o(ciphertext_data_o), .ciphertext_valid_o(ciphertext_valid_o),
        .ciphertext_ready_i(ciphertext_ready_i),
        .core_start_o(core_start_o), .core_block_o(core_block_o),
        .core_done_i(core_done_i), .core_block_i(core_block_i),
        .flags_busy_o(flags_busy_o), .flags_done_o(flags_done_o), .flags_blk_cnt_o(flags_blk_cnt_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;

    // stimulus knobs
    bit k_rst = 1, k_clr = 0, k_start = 0, k_spur = 0, k_fixed = 0;
    int k_nb = 0, k_en_pct = 100, k_pv_pct = 100, k_cr_pct = 100, k_lat_min = 1, k_lat_max = 4;
    logic [127:0] k_core_res = '0;

    // core emulator and stream bookkeeping
    int           core_cd = 0;
    logic [127:0] core_res = '0;
    logic [31:0]  src_q[$];
    logic [31:0]  cap_q[$];
    logic [127:0] cb_cap = '0;
    int           n_in = 0, n_out = 0, n_done_dut = 0;

    // behavioural model: job / block progress as counts
    bit           m_job, m_done_now, m_started, m_ret;
    int           m_nb, m_blk, m_in, m_out;
    logic [127:0] m_obuf, exp_blk;

    function automatic logic [31:0] sw(input logic [31:0] w);
`ifdef AES_ENGINE_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic m_reset();
        m_job = 0; m_done_now = 0; m_started = 0; m_ret = 0;
        m_nb = 0; m_blk = 0; m_in = 0; m_out = 0;
        m_obuf = '0; exp_blk = '0;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        logic ready_e, start_e, valid_e, busy_e, done_e, accept, hs_in, hs_out, nd;
        logic [31:0]  data_e;
        logic [127:0] tmp;
        @(negedge clk);
        reset_n           = !k_rst;
        ctrl_clear_i      = k_clr;
        ctrl_start_i      = k_start;
        nb_blocks_i       = k_start ? NBW'(k_nb) : NBW'($urandom);
        ctrl_enable_i     = ($urandom_range(99) < k_en_pct);
        plaintext_valid_i = (src_q.size() > 0) && ($urandom_range(99) < k_pv_pct);
        plaintext_data_i  = plaintext_valid_i ? src_q[0] : $urandom;
        ciphertext_ready_i = ($urandom_range(99) < k_cr_pct);
        core_done_i       = 1'b0;
        core_block_i      = {$urandom, $urandom, $urandom, $urandom};
        if (core_cd > 0) begin
            core_cd--;
            if (core_cd == 0) begin
                core_done_i  = 1'b1;
                core_block_i = core_res;
            end
        end else if (k_spur && !(m_job && m_started && !m_ret) && $urandom_range(7) == 0) begin
            core_done_i = 1'b1;
        end
        #1;
        if (!reset_n) begin
            m_reset();
            core_cd = 0;
        end
        ready_e = m_job && m_in < 4 && ctrl_enable_i && !ctrl_clear_i;
        start_e = m_job && m_in == 4 && !m_started && ctrl_enable_i && !ctrl_clear_i && reset_n;
        valid_e = m_job && m_ret;
        tmp     = m_obuf >> (96 - 32 * m_out);
        data_e  = valid_e ? sw(tmp[31:0]) : 32'h0;
        busy_e  = m_job || m_done_now;
        done_e  = m_done_now;
        chk("plaintext_ready", 128'(plaintext_ready_o), 128'(ready_e));
        chk("core_start", 128'(core_start_o), 128'(start_e));
        chk("ct_valid", 128'(ciphertext_valid_o), 128'(valid_e));
        chk("ct_data", 128'(ciphertext_data_o), 128'(data_e));
        chk("busy", 128'(flags_busy_o), 128'(busy_e));
        chk("done", 128'(flags_done_o), 128'(done_e));
        chk("blk_cnt", 128'(flags_blk_cnt_o), 128'(NBW'(m_blk)));
        if (!reset_n) chk("core_block_rst", core_block_o, 128'h0);
        if (start_e) begin
            chk("core_block", core_block_o, exp_blk);
            cb_cap = core_block_o;
        end
        if (flags_done_o === 1'b1) n_done_dut++;
        if (!reset_n) return;
        hs_in  = ready_e && plaintext_valid_i;
        hs_out = valid_e && ciphertext_ready_i;
        if (hs_in) begin void'(src_q.pop_front()); n_in++; end
        if (hs_out) begin cap_q.push_back(ciphertext_data_o); n_out++; end
        if (start_e) begin
            core_cd  = $urandom_range(k_lat_max, k_lat_min);
            core_res = k_fixed ? k_core_res : {$urandom, $urandom, $urandom, $urandom};
        end
        if (ctrl_clear_i) begin
            m_reset();
            return;
        end
        accept = m_job && m_in == 4 && m_started && !m_ret && core_done_i;
        nd = 0;
        if (m_done_now) begin
            // job finished last cycle; back to idle
        end else if (!m_job) begin
            if (ctrl_start_i) begin
                m_nb = int'(nb_blocks_i); m_blk = 0;
                if (m_nb == 0) nd = 1;
                else begin m_job = 1; m_in = 0; m_out = 0; m_started = 0; m_ret = 0; end
            end
        end else begin
            if (hs_in) begin
                exp_blk[127 - 32 * m_in -: 32] = sw(plaintext_data_i);
                m_in++;
            end
            if (start_e) m_started = 1;
            if (accept) begin m_ret = 1; m_obuf = core_block_i; m_out = 0; end
            if (hs_out) begin
                m_out++;
                if (m_out == 4) begin
                    m_blk = (m_blk + 1) % (1 << NBW);
                    m_ret = 0; m_in = 0; m_started = 0;
                    if (m_blk == m_nb) begin m_job = 0; nd = 1; end
                end
            end
        end
        m_done_now = nd;
    endtask

    function automatic bit cond(input int what);
        case (what)
            0: return !m_job && !m_done_now;
            1: return m_job && m_ret;
            2: return m_job && m_in == 2 && !m_started;
            3: return m_job && m_started && !m_ret;
            default: return 1'b1;
        endcase
    endfunction

    task automatic wait_model(input int what, input int budget);
        for (int i = 0; i < budget && !cond(what); i++) step();
        n_cmp++;
        if (!cond(what)) begin
            n_err++;
            $display("FAIL wait_%0d: condition not reached within %0d cycles", what, budget);
        end
    endtask

    task automatic start_job(input int nb);
        k_nb = nb; k_start = 1;
        step();
        k_start = 0;
    endtask

    task automatic run_job(input int nb);
        start_job(nb);
        wait_model(0, 3000);
        step();
    endtask

    initial begin
        m_reset();
        k_rst = 1;
        repeat (3) step();
        k_rst = 0;
        step();

        // single directed block with known vectors
        k_fixed = 1; k_core_res = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
        src_q = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
        cap_q.delete(); n_done_dut = 0;
        run_job(1);
`ifdef AES_ENGINE_BYTESWAP_EN
        chk("lit_block", cb_cap, 128'h33221100_77665544_BBAA9988_FFEEDDCC);
        chk("lit_w0", 128'(cap_q.size() > 0 ? cap_q[0] : 32'hx), 128'(32'hD8E0C469));
        chk("lit_w1", 128'(cap_q.size() > 1 ? cap_q[1] : 32'hx), 128'(32'h30047B6A));
        chk("lit_w2", 128'(cap_q.size() > 2 ? cap_q[2] : 32'hx), 128'(32'h80B7CDD8));
        chk("lit_w3", 128'(cap_q.size() > 3 ? cap_q[3] : 32'hx), 128'(32'h5AC5B470));
`else
        chk("lit_block", cb_cap, 128'h00112233445566778899AABBCCDDEEFF);
        chk("lit_w0", 128'(cap_q.size() > 0 ? cap_q[0] : 32'hx), 128'(32'h69C4E0D8));
        chk("lit_w1", 128'(cap_q.size() > 1 ? cap_q[1] : 32'hx), 128'(32'h6A7B0430));
        chk("lit_w2", 128'(cap_q.size() > 2 ? cap_q[2] : 32'hx), 128'(32'hD8CDB780));
        chk("lit_w3", 128'(cap_q.size() > 3 ? cap_q[3] : 32'hx), 128'(32'h70B4C55A));
`endif
        chk("lit_done_cnt", 128'(n_done_dut), 128'd1);
        chk("lit_blk_cnt1", 128'(flags_blk_cnt_o), 128'd1);
        k_fixed = 0;

        // three blocks with random gaps, enable drops and spurious core_done
        k_pv_pct = 60; k_cr_pct = 60; k_en_pct = 80; k_spur = 1; k_lat_max = 5;
        n_in = 0; n_out = 0; n_done_dut = 0;
        for (int i = 0; i < 12; i++) src_q.push_back($urandom);
        run_job(3);
        chk("three_in", 128'(n_in), 128'd12);
        chk("three_out", 128'(n_out), 128'd12);
        chk("three_done", 128'(n_done_dut), 128'd1);
        chk("three_cnt", 128'(flags_blk_cnt_o), 128'd3);

        // egress backpressure
        k_pv_pct = 100; k_cr_pct = 100; k_en_pct = 100; k_spur = 0;
        n_out = 0;
        for (int i = 0; i < 4; i++) src_q.push_back($urandom);
        start_job(1);
        wait_model(1, 200);
        k_cr_pct = 0;
        repeat (5) begin
            step();
            chk("bp_valid", 128'(ciphertext_valid_o), 128'd1);
        end
        k_cr_pct = 100;
        wait_model(0, 200);
        step();
        chk("bp_out", 128'(n_out), 128'd4);

        // enable low mid-load
        n_in = 0;
        for (int i = 0; i < 4; i++) src_q.push_back($urandom);
        start_job(1);
        wait_model(2, 200);
        k_en_pct = 0;
        repeat (4) begin
            step();
            chk("en_low_ready", 128'(plaintext_ready_o), 128'd0);
        end
        k_en_pct = 100;
        wait_model(0, 200);
        step();
        chk("en_in", 128'(n_in), 128'd4);

        // zero-block job
        n_in = 0; n_done_dut = 0;
        start_job(0);
        step();
        chk("zero_done", 128'(flags_done_o), 128'd1);
        step(); step();
        chk("zero_idle", 128'(flags_busy_o), 128'd0);
        chk("zero_in", 128'(n_in), 128'd0);
        chk("zero_done_cnt", 128'(n_done_dut), 128'd1);

        // clear while waiting on the core; the late result must not surface
        k_lat_min = 6; k_lat_max = 6;
        for (int i = 0; i < 4; i++) src_q.push_back($urandom);
        start_job(1);
        wait_model(3, 200);
        k_clr = 1;
        step();
        k_clr = 0;
        step();
        chk("clr_idle", 128'(flags_busy_o), 128'd0);
        repeat (10) step();
        chk("clr_no_valid", 128'(ciphertext_valid_o), 128'd0);
        k_lat_min = 1; k_lat_max = 4;

        // asynchronous reset during drain
        k_cr_pct = 0;
        for (int i = 0; i < 4; i++) src_q.push_back($urandom);
        start_job(1);
        wait_model(1, 200);
        k_rst = 1;
        step();
        chk("rst_valid", 128'(ciphertext_valid_o), 128'd0);
        chk("rst_cnt", 128'(flags_blk_cnt_o), 128'd0);
        k_rst = 0; k_cr_pct = 100;
        src_q.delete();
        repeat (2) step();

        // fresh job after clear and reset
        k_pv_pct = 70; k_cr_pct = 70; k_en_pct = 90;
        n_done_dut = 0;
        for (int i = 0; i < 8; i++) src_q.push_back($urandom);
        run_job(2);
        chk("post_cnt", 128'(flags_blk_cnt_o), 128'd2);
        chk("post_done", 128'(n_done_dut), 128'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
